cipher_frame_packer: RTL and testbench

Downstream stage of the keystream cipher core. It accepts encrypted bytes one at a time with a valid strobe and buffers them in a small FIFO. It emits framed packets on a byte-wide valid/ready output: SYNC byte, LENGTH byte, payload bytes, then an XOR checksum byte. It decouples the cipher's fixed 8-cycle byte cadence from a back-pressured output consumer.

---
 rtl/cipher_frame_packer_pkg.sv | 15 +
 rtl/cipher_frame_packer_if.sv | 13 +
 rtl/cipher_frame_packer_byte_fifo.sv | 58 +++++
 rtl/cipher_frame_packer.sv | 162 ++++++++++++++++
 tb/tb_cipher_frame_packer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_frame_packer_pkg.sv
// Shared definitions for the cipher output framing path: default SYNC
// marker and the framer state encoding (also used by the cipher top level).
package cipher_frame_packer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } frame_state_e;

endpackage

// File: rtl/cipher_frame_packer_if.sv
// Byte-wide valid/ready stream. The master drives valid/data, the slave
// drives ready. For the cipher input side ready is only advisory: the
// cipher has a fixed cadence and does not stall on it.
interface cipher_frame_packer_if;

  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/cipher_frame_packer_byte_fifo.sv
// Small synchronous byte FIFO with first-word look-ahead on head.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Overflow policy lives in the parent; push must only be asserted when
// the FIFO is not full.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cipher_frame_packer.sv
// Frames buffered cipher bytes as SYNC, LENGTH, payload, XOR checksum on a
// back-pressured byte stream. Partial frames are closed by a flush pulse.
module cipher_frame_packer
  import cipher_frame_packer_pkg::*;
#(
  parameter int         FRAME_LEN  = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cipher_frame_packer_if.slave  in_bus,
  cipher_frame_packer_if.master out_bus,
  input  logic                  flush,
  output logic                  overflow,
  output logic [7:0]            frame_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          push;
  logic          pop;

  frame_state_e  state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [CW-1:0] plen_q, plen_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          flush_pend_q, flush_pend_d;
  logic          overflow_q;
  logic          handshake;
  logic          launch;

  assign push          = in_bus.valid && !fifo_full;
  assign in_bus.ready  = !fifo_full;
  assign handshake     = out_valid_q && out_bus.ready;
  assign launch        = (fifo_count >= FRAME_LEN_C) || (flush_pend_q && !fifo_empty);

  assign out_bus.valid = out_valid_q;
  assign out_bus.data  = out_data_q;
  assign overflow      = overflow_q;
  assign frame_count   = frame_count_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_bus.data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky drop flag: a byte arriving while full is lost even if a pop frees space this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (in_bus.valid && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  // Framer next-state, output byte, checksum and pop decisions.
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    plen_d        = plen_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    frame_count_d = frame_count_q;
    flush_pend_d  = flush_pend_q || flush;
    pop           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          plen_d       = (fifo_count >= FRAME_LEN_C) ? FRAME_LEN_C : fifo_count;
          acc_d        = '0;
          out_data_d   = SYNC_BYTE;
          out_valid_d  = 1'b1;
          flush_pend_d = flush;
          state_d      = ST_SYNC;
        end else if (fifo_empty) begin
          flush_pend_d = flush;
        end
      end
      ST_SYNC: begin
        if (handshake) begin
          out_data_d = 8'(plen_q);
          state_d    = ST_LEN;
        end
      end
      ST_LEN: begin
        if (handshake) begin
          pop        = 1'b1;
          out_data_d = fifo_head;
          acc_d      = acc_q ^ fifo_head;
          rem_d      = plen_q - CW'(1);
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (handshake) begin
          if (rem_q != '0) begin
            pop        = 1'b1;
            out_data_d = fifo_head;
            acc_d      = acc_q ^ fifo_head;
            rem_d      = rem_q - CW'(1);
          end else begin
            out_data_d = acc_q;
            state_d    = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (handshake) begin
          out_valid_d   = 1'b0;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Framer state registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      plen_q        <= '0;
      rem_q         <= '0;
      acc_q         <= '0;
      frame_count_q <= '0;
      flush_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      plen_q        <= plen_d;
      rem_q         <= rem_d;
      acc_q         <= acc_d;
      frame_count_q <= frame_count_d;
      flush_pend_q  <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_cipher_frame_packer.sv
// Self-checking bench for cipher_frame_packer: directed scenarios plus
// randomized frames with random back-pressure, compared against a
// frame-level model (SYNC, length, payload, XOR of payload).
module tb_cipher_frame_packer;
  import cipher_frame_packer_pkg::*;

  localparam int FRAME_LEN = 4;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       overflow;
  logic [7:0] frame_count;

  cipher_frame_packer_if in_if ();
  cipher_frame_packer_if out_if ();

  cipher_frame_packer #(
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (4),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bus      (in_if.slave),
    .out_bus     (out_if.master),
    .flush       (flush),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_fc  = 8'd0;
  logic       model_ovf = 1'b0;
  bit         rand_ready = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advances to just after the next rising edge, optionally jittering out_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_if.ready = 1'($urandom_range(0, 1));
  endtask

  // Presents one cycle of cipher input and/or a flush pulse.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
    in_if.valid = v;
    in_if.data  = d;
    flush       = f;
    tick();
    in_if.valid = 1'b0;
    flush       = 1'b0;
  endtask

  // Frame model: SYNC, length, payload bytes, XOR of payload.
  task automatic addFrame(input logic [7:0] pl[$]);
    logic [7:0] x = 8'd0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      x = x ^ pl[i];
    end
    exp_q.push_back(x);
    model_fc = model_fc + 8'd1;
  endtask

  // Waits (bounded) for the expected stream and compares it byte by byte.
  task automatic drainAndCompare(input string tag);
    int budget = 0;
    while (got_q.size() < exp_q.size() && budget < 600) begin
      tick();
      budget++;
    end
    tick();
    tick();
    checkOutput({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checkOutput($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    end
    checkOutput({tag, "_fc"}, frame_count, model_fc);
    checkOutput({tag, "_ovf"}, overflow, model_ovf);
    got_q.delete();
    exp_q.delete();
  endtask

  // Output monitor: records accepted bytes and checks stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        checkOutput("hold_valid", out_if.valid, 1'b1);
        checkOutput("hold_data", out_if.data, prev_data);
      end
      if (out_if.valid && out_if.ready) got_q.push_back(out_if.data);
      prev_stall = out_if.valid && !out_if.ready;
      prev_data  = out_if.data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence.
  initial begin
    logic [7:0] pl[$];
    int seen;

    rst_n        = 1'b0;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = 8'd0;
    out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_if.valid, 1'b0);
    checkOutput("rst_out_data", out_if.data, 8'h00);
    checkOutput("rst_in_ready", in_if.ready, 1'b1);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_frame_count", frame_count, 8'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic full frame with launch latency");
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (pl[i]) applyStimulus(1'b1, pl[i], 1'b0);
    checkOutput("launch_lat0", out_if.valid, 1'b0);
    tick();
    checkOutput("launch_lat1", out_if.valid, 1'b1);
    addFrame(pl);
    drainAndCompare("basic");

    $display("[TB] flushed partial frame");
    pl = '{8'h5A, 8'h0F};
    foreach (pl[i]) applyStimulus(1'b1, pl[i], 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    addFrame(pl);
    drainAndCompare("flush");
    checkOutput("flush_in_ready", in_if.ready, 1'b1);

    $display("[TB] back-pressure on LEN byte");
    out_if.ready = 1'b0;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (pl[i]) applyStimulus(1'b1, pl[i], 1'b0);
    for (int i = 0; i < 20 && !out_if.valid; i++) tick();
    out_if.ready = 1'b1;
    tick();
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp_valid%0d", i), out_if.valid, 1'b1);
      checkOutput($sformatf("bp_data%0d", i), out_if.data, 8'h04);
    end
    out_if.ready = 1'b1;
    addFrame(pl);
    drainAndCompare("bp");

    $display("[TB] overflow with stalled output");
    out_if.ready = 1'b0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (pl[i]) applyStimulus(1'b1, pl[i], 1'b0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    model_ovf = 1'b1;
    checkOutput("ovf_flag", overflow, 1'b1);
    checkOutput("ovf_in_ready", in_if.ready, 1'b0);
    out_if.ready = 1'b1;
    addFrame(pl);
    drainAndCompare("ovf");

    $display("[TB] flush with empty FIFO");
    applyStimulus(1'b0, 8'h00, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_if.valid) seen++;
    end
    checkOutput("flush_empty_quiet", seen, 0);
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
    foreach (pl[i]) begin
      applyStimulus(1'b1, pl[i], 1'b0);
      tick();
      tick();
    end
    addFrame(pl);
    drainAndCompare("flush_empty");

    $display("[TB] randomized frames with random back-pressure");
    rand_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int k = $urandom_range(1, FRAME_LEN);
      pl.delete();
      for (int i = 0; i < k; i++) pl.push_back(8'($urandom));
      foreach (pl[i]) begin
        repeat ($urandom_range(0, 2)) tick();
        applyStimulus(1'b1, pl[i], 1'b0);
      end
      if (k < FRAME_LEN) applyStimulus(1'b0, 8'h00, 1'b1);
      addFrame(pl);
      drainAndCompare("rnd");
    end
    rand_ready   = 1'b0;
    out_if.ready = 1'b1;
    tick();

    $display("[TB] reset in the middle of a payload");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 30 && got_q.size() < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_if.valid, 1'b0);
    checkOutput("midrst_frame_count", frame_count, 8'd0);
    checkOutput("midrst_in_ready", in_if.ready, 1'b1);
    checkOutput("midrst_overflow", overflow, 1'b0);
    got_q.delete();
    exp_q.delete();
    model_fc  = 8'd0;
    model_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (pl[i]) applyStimulus(1'b1, pl[i], 1'b0);
    addFrame(pl);
    drainAndCompare("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
